// File: rtl/gray_counter_if.sv
// gray_counter_if: control and count bundle for gray_counter.
//   master : drives the step/load controls, observes the count
//   slave  : the counter side (receives controls, drives the count)
// Signals:
//   en           step enable, one step per cycle when high
//   up_dn        step direction (1 = up, 0 = down)
//   load         parallel load strobe, wins over en
//   load_is_gray load_val is Gray-coded when high, binary when low
//   load_val     value to load
//   gray_out     registered Gray count
//   bin_out      registered binary count, always g2b(gray_out)
//   tc           registered terminal-count pulse
interface gray_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic             load_is_gray;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             tc;

  modport master (
    output en, up_dn, load, load_is_gray, load_val,
    input  gray_out, bin_out, tc
  );

  modport slave (
    input  en, up_dn, load, load_is_gray, load_val,
    output gray_out, bin_out, tc
  );
endinterface

// File: rtl/gray_counter.sv
// gray_counter: parametrised up/down Gray counter with binary or Gray
// parallel load and wrap/saturate limit behaviour. The binary count and
// its Gray image are both registered from the same next-state value, so
// they change on the same edge and never disagree.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (count -> RESET_BIN, tc -> 0)
//   cnt_if  gray_counter_if.slave: en/up_dn/load/load_is_gray/load_val in,
//           gray_out/bin_out/tc out
module gray_counter #(
  parameter int WIDTH     = 8,
  parameter int SATURATE  = 0,
  parameter int RESET_BIN = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  gray_counter_if.slave cnt_if
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_BIN);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_MIN  = '0;
  localparam logic             SAT      = (SATURATE != 0);

  // Which update applies this cycle, in priority order.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DN   = 2'd3
  } op_e;

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q,   tc_d;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] load_sel;
  logic             at_max, at_min;
  op_e              op;

  // Gray -> binary of the load value: prefix XOR from the MSB down.
  always_comb begin
    load_bin            = '0;
    load_bin[WIDTH-1]   = cnt_if.load_val[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      load_bin[i] = load_bin[i+1] ^ cnt_if.load_val[i];
    end
  end

  assign load_sel = cnt_if.load_is_gray ? load_bin : cnt_if.load_val;
  assign at_max   = (bin_q == CNT_MAX);
  assign at_min   = (bin_q == CNT_MIN);

  always_comb begin
    op = OP_HOLD;
    if (cnt_if.load)       op = OP_LOAD;
    else if (cnt_if.en)    op = cnt_if.up_dn ? OP_UP : OP_DN;
  end

  // Next state. A limit hit raises tc whether we wrap or hold; in
  // saturate mode the count simply stays put.
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    unique case (op)
      OP_LOAD: bin_d = load_sel;
      OP_UP: begin
        if (at_max) begin
          tc_d  = 1'b1;
          bin_d = SAT ? bin_q : CNT_MIN;
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end
      OP_DN: begin
        if (at_min) begin
          tc_d  = 1'b1;
          bin_d = SAT ? bin_q : CNT_MAX;
        end else begin
          bin_d = bin_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Gray image is formed from bin_d so both registers load together.
  assign gray_d = bin_d ^ (bin_d >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign cnt_if.bin_out  = bin_q;
  assign cnt_if.gray_out = gray_q;
  assign cnt_if.tc       = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed checks of gray_counter (WIDTH = 8) on three
// instances: wrap/reset 0 (a), saturate/reset 0 (s), wrap/reset 0x10 (r).
module tb_gray_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gray_counter_if #(.WIDTH(8)) a_if ();
  gray_counter_if #(.WIDTH(8)) s_if ();
  gray_counter_if #(.WIDTH(8)) r_if ();

  gray_counter #(.WIDTH(8), .SATURATE(0), .RESET_BIN(0))     u_a (.clk(clk), .rst_n(rst_n), .cnt_if(a_if.slave));
  gray_counter #(.WIDTH(8), .SATURATE(1), .RESET_BIN(0))     u_s (.clk(clk), .rst_n(rst_n), .cnt_if(s_if.slave));
  gray_counter #(.WIDTH(8), .SATURATE(0), .RESET_BIN('h10))  u_r (.clk(clk), .rst_n(rst_n), .cnt_if(r_if.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gray -> binary as b = g ^ g>>1 ^ g>>2 ^ ...
  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int s = 1; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  initial begin
    logic [7:0] prev_g;
    logic [7:0] exp_b;
    logic       exp_tc;

    a_if.en = 0; a_if.up_dn = 0; a_if.load = 0; a_if.load_is_gray = 0; a_if.load_val = 0;
    s_if.en = 0; s_if.up_dn = 0; s_if.load = 0; s_if.load_is_gray = 0; s_if.load_val = 0;
    r_if.en = 0; r_if.up_dn = 0; r_if.load = 0; r_if.load_is_gray = 0; r_if.load_val = 0;

    // Reset applied before any clock edge: outputs must be forced at once.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_a_bin",  a_if.bin_out,  8'h00);
    chk("rst_a_gray", a_if.gray_out, 8'h00);
    chk("rst_a_tc",   a_if.tc,       1'b0);
    chk("rst_r_bin",  r_if.bin_out,  8'h10);
    chk("rst_r_gray", r_if.gray_out, 8'h18);
    chk("rst_r_tc",   r_if.tc,       1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // Five up steps, single-bit Gray change on each.
    a_if.en = 1; a_if.up_dn = 1;
    for (int i = 0; i < 5; i++) begin
      prev_g = a_if.gray_out;
      tick();
      chk("up5_onebit", $countones(prev_g ^ a_if.gray_out), 1);
    end
    chk("up5_bin",  a_if.bin_out,  8'h05);
    chk("up5_gray", a_if.gray_out, 8'h07);
    chk("up5_tc",   a_if.tc,       1'b0);

    // Binary load of 0xFF, then one up step wraps.
    a_if.en = 0; a_if.load = 1; a_if.load_is_gray = 0; a_if.load_val = 8'hFF;
    tick();
    chk("ldff_bin",  a_if.bin_out,  8'hFF);
    chk("ldff_gray", a_if.gray_out, 8'h80);
    chk("ldff_tc",   a_if.tc,       1'b0);
    a_if.load = 0; a_if.en = 1; a_if.up_dn = 1;
    tick();
    chk("wrap_bin",  a_if.bin_out,  8'h00);
    chk("wrap_gray", a_if.gray_out, 8'h00);
    chk("wrap_tc",   a_if.tc,       1'b1);
    a_if.en = 0;
    tick();
    chk("wrap_tc_drop", a_if.tc,      1'b0);
    chk("hold_bin",     a_if.bin_out, 8'h00);

    // Gray load of 0x80 with en high: load wins, no extra step.
    a_if.load = 1; a_if.load_is_gray = 1; a_if.load_val = 8'h80; a_if.en = 1; a_if.up_dn = 1;
    tick();
    chk("ldg80_bin",  a_if.bin_out,  8'hFF);
    chk("ldg80_gray", a_if.gray_out, 8'h80);
    chk("ldg80_tc",   a_if.tc,       1'b0);

    // Reverse direction right away: FF -> FE.
    a_if.load = 0; a_if.up_dn = 0;
    tick();
    chk("dn_bin",  a_if.bin_out,  8'hFE);
    chk("dn_gray", a_if.gray_out, 8'h81);
    chk("dn_tc",   a_if.tc,       1'b0);

    // Down wrap from zero.
    a_if.load = 1; a_if.load_is_gray = 0; a_if.load_val = 8'h00;
    tick();
    a_if.load = 0;
    tick();
    chk("dnwrap_bin",  a_if.bin_out,  8'hFF);
    chk("dnwrap_gray", a_if.gray_out, 8'h80);
    chk("dnwrap_tc",   a_if.tc,       1'b1);

    // Gray load of 0xC5 -> binary 0x86.
    a_if.en = 0; a_if.load = 1; a_if.load_is_gray = 1; a_if.load_val = 8'hC5;
    tick();
    chk("ldgc5_bin",  a_if.bin_out,  8'h86);
    chk("ldgc5_gray", a_if.gray_out, 8'hC5);

    // Mid-count asynchronous reset at 0x42.
    a_if.load_is_gray = 0; a_if.load_val = 8'h41;
    tick();
    a_if.load = 0; a_if.en = 1; a_if.up_dn = 1;
    tick();
    chk("pre_rst_bin", a_if.bin_out, 8'h42);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bin",  a_if.bin_out,  8'h00);
    chk("mid_rst_gray", a_if.gray_out, 8'h00);
    chk("mid_rst_tc",   a_if.tc,       1'b0);
    chk("mid_rst_rbin", r_if.bin_out,  8'h10);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_bin",  a_if.bin_out,  8'h01);
    chk("post_rst_gray", a_if.gray_out, 8'h01);
    a_if.en = 0;

    // Saturate instance: three down steps at 0 hold with tc high.
    s_if.en = 1; s_if.up_dn = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_lo_bin", s_if.bin_out, 8'h00);
      chk("sat_lo_tc",  s_if.tc,      1'b1);
    end
    s_if.up_dn = 1;
    tick();
    chk("sat_up_bin", s_if.bin_out, 8'h01);
    chk("sat_up_tc",  s_if.tc,      1'b0);
    s_if.load = 1; s_if.load_val = 8'hFF;
    tick();
    chk("sat_ld_tc", s_if.tc, 1'b0);
    s_if.load = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sat_hi_bin",  s_if.bin_out,  8'hFF);
      chk("sat_hi_gray", s_if.gray_out, 8'h80);
      chk("sat_hi_tc",   s_if.tc,       1'b1);
    end
    s_if.en = 0;

    // RESET_BIN = 0x10 instance: full up sweep then full down sweep.
    exp_b = 8'h10;
    r_if.en = 1; r_if.up_dn = 1;
    for (int i = 0; i < 256; i++) begin
      prev_g = r_if.gray_out;
      exp_tc = (exp_b == 8'hFF);
      exp_b  = exp_b + 8'd1;
      tick();
      chk("swp_up_bin",    r_if.bin_out, exp_b);
      chk("swp_up_g2b",    r_if.bin_out, g2b(r_if.gray_out));
      chk("swp_up_tc",     r_if.tc,      exp_tc);
      chk("swp_up_onebit", $countones(prev_g ^ r_if.gray_out), 1);
    end
    r_if.up_dn = 0;
    for (int i = 0; i < 256; i++) begin
      prev_g = r_if.gray_out;
      exp_tc = (exp_b == 8'h00);
      exp_b  = exp_b - 8'd1;
      tick();
      chk("swp_dn_bin",    r_if.bin_out, exp_b);
      chk("swp_dn_g2b",    r_if.bin_out, g2b(r_if.gray_out));
      chk("swp_dn_tc",     r_if.tc,      exp_tc);
      chk("swp_dn_onebit", $countones(prev_g ^ r_if.gray_out), 1);
    end
    r_if.en = 0;
    chk("swp_end_bin", r_if.bin_out, 8'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
